cub_crossbar_rr: RTL and testbench

//  Registered, flow-controlled CH_IN x CH_OUT crossbar for the CU bank ALU dataflow. Routes input beats
//  to outputs per a programmable bitmask (unicast or multicast). Per-output round-robin arbitration

---
 rtl/cub_crossbar_rr.sv | 158 +++++++++++++++
 tb/tb_cub_crossbar_rr.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cub_crossbar_rr.sv
// Registered CH_IN x CH_OUT crossbar: bitmask routing (unicast/multicast), per-output round-robin.
// Optional per-output delivery counters when CUB_XBAR_STAT_EN is defined.
module cub_crossbar_rr #(
    parameter int unsigned DWID   = 32,
    parameter int unsigned CH_IN  = 5,
    parameter int unsigned CH_OUT = 5
`ifdef CUB_XBAR_STAT_EN
    ,
    parameter int unsigned CNT_W  = 16
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cub_crbr_cfg_we,
    input  logic [CH_OUT-1:0][CH_IN-1:0] cub_crbr_cfg_bitmask,
    output logic                         cub_crbr_cfg_err,
    output logic                         cub_crbr_idle,
    input  logic [CH_IN-1:0][DWID-1:0]   cub_crbr_cflow_data_in,
    input  logic [CH_IN-1:0]             cub_crbr_cflow_valid_in,
    output logic [CH_IN-1:0]             cub_crbr_cflow_ready_in,
    output logic [CH_OUT-1:0][DWID-1:0]  cub_crbr_cflow_data_out,
    output logic [CH_OUT-1:0]            cub_crbr_cflow_valid_out,
    input  logic [CH_OUT-1:0]            cub_crbr_cflow_ready_out
`ifdef CUB_XBAR_STAT_EN
    ,
    input  logic                         cub_crbr_stat_clr,
    output logic [CH_OUT-1:0][CNT_W-1:0] cub_crbr_stat_cnt
`endif
);

    localparam int unsigned PTR_W = (CH_IN > 1) ? $clog2(CH_IN) : 1;

    logic [CH_OUT-1:0][CH_IN-1:0] mask_q;
    logic [CH_IN-1:0][CH_OUT-1:0] done_q;
    logic [CH_IN-1:0][CH_OUT-1:0] done_d;
    logic [CH_OUT-1:0][PTR_W-1:0] ptr_q;
    logic [CH_OUT-1:0][PTR_W-1:0] ptr_d;
    logic [CH_OUT-1:0][CH_IN-1:0] req;
    logic [CH_OUT-1:0][CH_IN-1:0] sel_vec;
    logic [CH_OUT-1:0][CH_IN-1:0] grant;
    logic [CH_OUT-1:0][PTR_W-1:0] sel_idx;
    logic [CH_OUT-1:0][DWID-1:0]  gnt_data;
    logic [CH_OUT-1:0]            hit;
    logic [CH_OUT-1:0]            slot_free;
    logic [CH_OUT-1:0]            gnt_any;
    logic [CH_IN-1:0]             has_route;
    logic [CH_IN-1:0]             covered;

    // Round-robin pick per output: first scan ptr..CH_IN-1, then wrap to 0..ptr-1
    always_comb begin
        req      = '0;
        hit      = '0;
        sel_vec  = '0;
        sel_idx  = '0;
        gnt_data = '0;
        for (int o = 0; o < CH_OUT; o++) begin
            for (int i = 0; i < CH_IN; i++) begin
                req[o][i] = cub_crbr_cflow_valid_in[i] & mask_q[o][i] & ~done_q[i][o];
            end
            for (int i = 0; i < CH_IN; i++) begin
                if (!hit[o] && req[o][i] && (PTR_W'(i) >= ptr_q[o])) begin
                    hit[o]        = 1'b1;
                    sel_vec[o][i] = 1'b1;
                    sel_idx[o]    = PTR_W'(i);
                    gnt_data[o]   = cub_crbr_cflow_data_in[i];
                end
            end
            for (int i = 0; i < CH_IN; i++) begin
                if (!hit[o] && req[o][i]) begin
                    hit[o]        = 1'b1;
                    sel_vec[o][i] = 1'b1;
                    sel_idx[o]    = PTR_W'(i);
                    gnt_data[o]   = cub_crbr_cflow_data_in[i];
                end
            end
        end
    end

    // A pick becomes a grant only if the output register can take it this cycle
    always_comb begin
        slot_free = ~cub_crbr_cflow_valid_out | cub_crbr_cflow_ready_out;
        gnt_any   = hit & slot_free;
        grant     = '0;
        ptr_d     = ptr_q;
        for (int o = 0; o < CH_OUT; o++) begin
            if (gnt_any[o]) begin
                grant[o] = sel_vec[o];
                ptr_d[o] = (sel_idx[o] == PTR_W'(CH_IN - 1)) ? '0 : sel_idx[o] + PTR_W'(1);
            end
        end
    end

    // An input retires once every targeted output has taken the beat, earlier or now
    always_comb begin
        has_route = '0;
        covered   = '1;
        done_d    = '0;
        for (int i = 0; i < CH_IN; i++) begin
            for (int o = 0; o < CH_OUT; o++) begin
                has_route[i] = has_route[i] | mask_q[o][i];
                covered[i]   = covered[i] & (~mask_q[o][i] | done_q[i][o] | grant[o][i]);
            end
        end
        for (int i = 0; i < CH_IN; i++) begin
            for (int o = 0; o < CH_OUT; o++) begin
                done_d[i][o] = cub_crbr_cflow_ready_in[i] ? 1'b0 : (done_q[i][o] | grant[o][i]);
            end
        end
    end

    assign cub_crbr_cflow_ready_in = cub_crbr_cflow_valid_in & has_route & covered;
    assign cub_crbr_idle = ~|cub_crbr_cflow_valid_in & ~|done_q & ~|cub_crbr_cflow_valid_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q                   <= '0;
            done_q                   <= '0;
            ptr_q                    <= '0;
            cub_crbr_cfg_err         <= 1'b0;
            cub_crbr_cflow_valid_out <= '0;
            cub_crbr_cflow_data_out  <= '0;
        end else begin
            done_q           <= done_d;
            ptr_q            <= ptr_d;
            cub_crbr_cfg_err <= cub_crbr_cfg_we & ~cub_crbr_idle;
            if (cub_crbr_cfg_we && cub_crbr_idle) begin
                mask_q <= cub_crbr_cfg_bitmask;
            end
            for (int o = 0; o < CH_OUT; o++) begin
                if (gnt_any[o]) begin
                    cub_crbr_cflow_valid_out[o] <= 1'b1;
                    cub_crbr_cflow_data_out[o]  <= gnt_data[o];
                end else if (cub_crbr_cflow_ready_out[o]) begin
                    cub_crbr_cflow_valid_out[o] <= 1'b0;
                end
            end
        end
    end

`ifdef CUB_XBAR_STAT_EN
    // Saturating delivery counters; clear beats a same-cycle increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cub_crbr_stat_cnt <= '0;
        end else begin
            for (int o = 0; o < CH_OUT; o++) begin
                if (cub_crbr_stat_clr) begin
                    cub_crbr_stat_cnt[o] <= '0;
                end else if (cub_crbr_cflow_valid_out[o] && cub_crbr_cflow_ready_out[o]
                             && (cub_crbr_stat_cnt[o] != '1)) begin
                    cub_crbr_stat_cnt[o] <= cub_crbr_stat_cnt[o] + CNT_W'(1);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cub_crossbar_rr.sv
// Self-checking bench for cub_crossbar_rr: directed scenarios plus randomized traffic
// against a per-output, per-source expected-beat scoreboard.
`timescale 1ns/1ps
module tb_cub_crossbar_rr;
    localparam int unsigned DW = 32;
    localparam int unsigned NI = 5;
    localparam int unsigned NO = 5;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   cfg_we;
    logic [NO-1:0][NI-1:0]  cfg_mask;
    logic                   cfg_err;
    logic                   idle;
    logic [NI-1:0][DW-1:0]  din;
    logic [NI-1:0]          vin;
    logic [NI-1:0]          rin;
    logic [NO-1:0][DW-1:0]  dout;
    logic [NO-1:0]          vout;
    logic [NO-1:0]          rout;
`ifdef CUB_XBAR_STAT_EN
    logic                   stat_clr;
    logic [NO-1:0][3:0]     stat_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] exp_q [NO][NI][$];

    always #5 clk = ~clk;

    cub_crossbar_rr #(
        .DWID(DW), .CH_IN(NI), .CH_OUT(NO)
`ifdef CUB_XBAR_STAT_EN
        , .CNT_W(4)
`endif
    ) dut (
        .clk(clk), .rst(rst),
        .cub_crbr_cfg_we(cfg_we), .cub_crbr_cfg_bitmask(cfg_mask),
        .cub_crbr_cfg_err(cfg_err), .cub_crbr_idle(idle),
        .cub_crbr_cflow_data_in(din), .cub_crbr_cflow_valid_in(vin),
        .cub_crbr_cflow_ready_in(rin), .cub_crbr_cflow_data_out(dout),
        .cub_crbr_cflow_valid_out(vout), .cub_crbr_cflow_ready_out(rout)
`ifdef CUB_XBAR_STAT_EN
        , .cub_crbr_stat_clr(stat_clr), .cub_crbr_stat_cnt(stat_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; cfg_we = 1'b0; cfg_mask = '0; vin = '0; din = '0; rout = '1;
`ifdef CUB_XBAR_STAT_EN
        stat_clr = 1'b0;
`endif
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic load_cfg(input logic [NO-1:0][NI-1:0] m);
        cfg_mask = m; cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
    endtask

    // Beat tag: source in the top byte, per-source sequence, random filler
    function automatic logic [DW-1:0] beat(input int src, input int seq);
        return {8'(src), 16'(seq), 8'($urandom)};
    endfunction

    function automatic logic [NO-1:0][NI-1:0] ident_mask();
        logic [NO-1:0][NI-1:0] m = '0;
        for (int o = 0; o < NO; o++) m[o][o] = 1'b1;
        return m;
    endfunction

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_cmp++; if (vout !== '0) begin n_err++; $display("FAIL reset_valid_out: got %b want 0", vout); end
        n_cmp++; if (dout !== '0) begin n_err++; $display("FAIL reset_data_out: got %h want 0", dout); end
        n_cmp++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL reset_cfg_err: got %b want 0", cfg_err); end
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL reset_idle: got %b want 1", idle); end
        vin = '1;
        for (int i = 0; i < NI; i++) din[i] = beat(i, 0);
        #1;
        n_cmp++; if (rin !== '0) begin n_err++; $display("FAIL no_route_ready: got %b want 0", rin); end
        n_cmp++; if (idle !== 1'b0) begin n_err++; $display("FAIL busy_idle: got %b want 0", idle); end
        vin = '0;
        tick();
    endtask

    task automatic test_identity();
        logic [NI-1:0][DW-1:0] prev = '0;
        do_reset();
        load_cfg(ident_mask());
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < NI; i++) din[i] = beat(i, c);
            vin = '1;
            @(negedge clk);
            n_cmp++; if (rin !== '1) begin n_err++; $display("FAIL ident_ready c%0d: got %b want 11111", c, rin); end
            if (c == 0) begin
                n_cmp++; if (vout !== '0) begin n_err++; $display("FAIL ident_latency: got %b want 0", vout); end
            end else begin
                n_cmp++;
                if (vout !== '1 || dout !== prev) begin
                    n_err++; $display("FAIL ident_data c%0d: got %b/%h want 11111/%h", c, vout, dout, prev);
                end
            end
            prev = din;
            tick();
        end
        vin = '0;
        @(negedge clk);
        n_cmp++; if (vout !== '1 || dout !== prev) begin n_err++; $display("FAIL ident_last: got %h want %h", dout, prev); end
        tick();
        @(negedge clk);
        n_cmp++; if (vout !== '0) begin n_err++; $display("FAIL ident_drain: got %b want 0", vout); end
        tick();
    endtask

    task automatic test_rr_wrap();
        logic [NO-1:0][NI-1:0] m = '0;
        logic [NI-1:0] cons;
        int got[$];
        int seq[NI];
        int cyc = 0;
        int last = NI - 1;
        int exp_src;
        do_reset();
        m[1] = 5'b10101;
        load_cfg(m);
        for (int i = 0; i < NI; i++) seq[i] = 0;
        for (int i = 0; i < NI; i += 2) begin vin[i] = 1'b1; din[i] = beat(i, 0); end
        while (got.size() < 9 && cyc < 40) begin
            @(negedge clk);
            if (vout[1] && rout[1]) got.push_back(int'(dout[1][31:24]));
            cons = vin & rin;
            tick();
            cyc++;
            for (int i = 0; i < NI; i++) if (cons[i]) begin seq[i]++; din[i] = beat(i, seq[i]); end
        end
        vin = '0;
        n_cmp++; if (got.size() != 9) begin n_err++; $display("FAIL rr_timeout: got %0d beats want 9", got.size()); end
        for (int k = 0; k < got.size(); k++) begin
            exp_src = -1;
            for (int j = 1; j <= int'(NI) && exp_src < 0; j++)
                if (m[1][(last + j) % NI]) exp_src = (last + j) % NI;
            last = exp_src;
            n_cmp++; if (got[k] !== exp_src) begin n_err++; $display("FAIL rr_order k%0d: got %0d want %0d", k, got[k], exp_src); end
        end
        n_cmp++; if (cyc != 10) begin n_err++; $display("FAIL rr_throughput: got %0d cycles want 10", cyc); end
        tick(); tick();
    endtask

    task automatic test_multicast();
        logic [NO-1:0][NI-1:0] m = '0;
        logic [4:0] exp_rdy = 5'b10001;
        logic [DW-1:0] a, b;
        logic [DW-1:0] rx [NO][$];
        logic cons;
        do_reset();
        m[0][3] = 1'b1; m[1][3] = 1'b1; m[4][3] = 1'b1;
        load_cfg(m);
        a = beat(3, 0); b = beat(3, 1);
        rout = 5'b11101; vin[3] = 1'b1; din[3] = a;
        for (int c = 0; c < 8; c++) begin
            if (c == 4) rout = '1;
            @(negedge clk);
            for (int o = 0; o < NO; o++) if (vout[o] && rout[o]) rx[o].push_back(dout[o]);
            if (c <= 4) begin
                n_cmp++; if (rin[3] !== exp_rdy[c]) begin n_err++; $display("FAIL mc_ready c%0d: got %b want %b", c, rin[3], exp_rdy[c]); end
            end
            if (c >= 1 && c <= 3) begin
                n_cmp++; if (vout[1] !== 1'b1 || dout[1] !== a) begin n_err++; $display("FAIL mc_hold c%0d: got %h want %h", c, dout[1], a); end
            end
            cons = vin[3] & rin[3];
            tick();
            if (cons) begin
                if (c == 0) din[3] = b; else vin[3] = 1'b0;
            end
        end
        for (int o = 0; o < NO; o++) begin
            if (m[o][3]) begin
                n_cmp++;
                if (rx[o].size() != 2 || rx[o][0] !== a || rx[o][1] !== b)
                    begin n_err++; $display("FAIL mc_deliver o%0d: got %0d beats want 2 (a,b)", o, rx[o].size()); end
            end else begin
                n_cmp++; if (rx[o].size() != 0) begin n_err++; $display("FAIL mc_stray o%0d: got %0d beats want 0", o, rx[o].size()); end
            end
        end
    endtask

    task automatic test_stall();
        logic [NI-1:0] cons;
        logic [DW-1:0] held = '0;
        int seq[NI];
        do_reset();
        load_cfg(ident_mask());
        rout = 5'b11011; vin = '1;
        for (int i = 0; i < NI; i++) begin seq[i] = 0; din[i] = beat(i, 0); end
        for (int c = 0; c < 7; c++) begin
            if (c == 6) rout = '1;
            @(negedge clk);
            if (c == 0) held = din[2];
            if (c >= 1 && c <= 5) begin
                n_cmp++; if (vout[2] !== 1'b1 || dout[2] !== held) begin n_err++; $display("FAIL stall_hold c%0d: got %h want %h", c, dout[2], held); end
                n_cmp++; if (rin !== 5'b11011) begin n_err++; $display("FAIL stall_ready c%0d: got %b want 11011", c, rin); end
                n_cmp++; if (vout !== 5'b11111) begin n_err++; $display("FAIL stall_others c%0d: got %b want 11111", c, vout); end
            end
            if (c == 6) begin
                n_cmp++; if (rin[2] !== 1'b1) begin n_err++; $display("FAIL stall_release: got %b want 1", rin[2]); end
            end
            cons = vin & rin;
            tick();
            for (int i = 0; i < NI; i++) if (cons[i]) begin seq[i]++; din[i] = beat(i, seq[i]); end
        end
        vin = '0;
        tick(); tick();
    endtask

    task automatic test_cfg();
        logic [NO-1:0][NI-1:0] sh = '0;
        logic [NI-1:0][DW-1:0] sent;
        int w = 0;
        for (int i = 0; i < NI; i++) sh[(i + 1) % NO][i] = 1'b1;
        do_reset();
        load_cfg(ident_mask());
        vin = '1;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < NI; i++) din[i] = beat(i, c);
            if (c == 1) begin cfg_mask = sh; cfg_we = 1'b1; end else cfg_we = 1'b0;
            @(negedge clk);
            if (c == 1) begin
                n_cmp++; if (idle !== 1'b0) begin n_err++; $display("FAIL cfg_busy_idle: got %b want 0", idle); end
            end
            if (c >= 2) begin
                n_cmp++; if (cfg_err !== (c == 2)) begin n_err++; $display("FAIL cfg_err_pulse c%0d: got %b want %b", c, cfg_err, c == 2); end
            end
            if (c >= 1) begin
                for (int o = 0; o < NO; o++) begin
                    n_cmp++;
                    if (vout[o] !== 1'b1 || int'(dout[o][31:24]) != o)
                        begin n_err++; $display("FAIL cfg_route_kept c%0d o%0d: got src %0d want %0d", c, o, dout[o][31:24], o); end
                end
            end
            tick();
        end
        vin = '0; cfg_we = 1'b0;
        @(negedge clk);
        while (idle !== 1'b1 && w < 20) begin tick(); @(negedge clk); w++; end
        n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL cfg_idle_wait: got %b want 1", idle); end
        cfg_mask = sh; cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
        @(negedge clk);
        n_cmp++; if (cfg_err !== 1'b0) begin n_err++; $display("FAIL cfg_idle_err: got %b want 0", cfg_err); end
        tick();
        for (int i = 0; i < NI; i++) begin sent[i] = beat(i, 100); din[i] = sent[i]; end
        vin = '1;
        @(negedge clk);
        n_cmp++; if (rin !== '1) begin n_err++; $display("FAIL cfg_new_ready: got %b want 11111", rin); end
        tick();
        vin = '0;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            n_cmp++;
            if (vout[(i + 1) % NO] !== 1'b1 || dout[(i + 1) % NO] !== sent[i])
                begin n_err++; $display("FAIL cfg_new_map i%0d: got %h want %h", i, dout[(i + 1) % NO], sent[i]); end
        end
        tick(); tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        load_cfg(ident_mask());
        vin = '1;
        for (int i = 0; i < NI; i++) din[i] = beat(i, 7);
        tick(); tick();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (vout !== '0) begin n_err++; $display("FAIL arst_valid: got %b want 0", vout); end
        n_cmp++; if (dout !== '0) begin n_err++; $display("FAIL arst_data: got %h want 0", dout); end
        n_cmp++; if (rin !== '0) begin n_err++; $display("FAIL arst_mask: got %b want 0", rin); end
        tick();
        rst = 1'b0;
        vin = '0;
        tick();
    endtask

    task automatic test_random();
        logic [NO-1:0][NI-1:0] m;
        logic [NI-1:0] route = '0;
        logic [NI-1:0] cons;
        logic bad_vout = 1'b0, bad_rin = 1'b0, drain = 1'b0, all_empty = 1'b0;
        int seq[NI];
        int src;
        int cyc = 0;
        logic [DW-1:0] exp_b;
        do_reset();
        for (int o = 0; o < NO; o++) m[o] = NI'($urandom);
        m[3] = '0;
        for (int o = 0; o < NO; o++) m[o][1] = 1'b0;
        m[0][0] = 1'b1;
        for (int i = 0; i < NI; i++) begin
            seq[i] = 0;
            for (int o = 0; o < NO; o++) route[i] = route[i] | m[o][i];
        end
        load_cfg(m);
        for (int o = 0; o < NO; o++) for (int i = 0; i < NI; i++) exp_q[o][i].delete();
        while (cyc < 700 && !(drain && all_empty)) begin
            @(negedge clk);
            for (int o = 0; o < NO; o++) begin
                if (m[o] == '0 && vout[o]) bad_vout = 1'b1;
                if (vout[o] && rout[o]) begin
                    src = int'(dout[o][31:24]);
                    n_cmp++;
                    if (src >= int'(NI) || exp_q[o][src].size() == 0) begin
                        n_err++; $display("FAIL rnd_unexpected o%0d: got %h want no beat", o, dout[o]);
                    end else begin
                        exp_b = exp_q[o][src].pop_front();
                        if (dout[o] !== exp_b) begin n_err++; $display("FAIL rnd_order o%0d: got %h want %h", o, dout[o], exp_b); end
                    end
                end
            end
            if ((rin & ~route) != '0) bad_rin = 1'b1;
            cons = vin & rin;
            tick();
            cyc++;
            if (cyc >= 400) drain = 1'b1;
            rout = drain ? '1 : NO'($urandom);
            for (int i = 0; i < NI; i++) begin
                if (!route[i]) begin
                    vin[i] = ~drain;
                end else if (!vin[i] || cons[i]) begin
                    if (!drain && $urandom_range(0, 2) != 0) begin
                        seq[i]++;
                        din[i] = beat(i, seq[i]);
                        vin[i] = 1'b1;
                        for (int o = 0; o < NO; o++) if (m[o][i]) exp_q[o][i].push_back(din[i]);
                    end else begin
                        vin[i] = 1'b0;
                    end
                end
            end
            all_empty = ((vin & route) == '0);
            for (int o = 0; o < NO; o++) for (int i = 0; i < NI; i++) if (exp_q[o][i].size() != 0) all_empty = 1'b0;
        end
        n_cmp++; if (!all_empty) begin n_err++; $display("FAIL rnd_drain: got beats outstanding want none"); end
        n_cmp++; if (bad_vout !== 1'b0) begin n_err++; $display("FAIL rnd_unrouted_out: got valid want never"); end
        n_cmp++; if (bad_rin !== 1'b0) begin n_err++; $display("FAIL rnd_unrouted_in: got ready want never"); end
        vin = '0;
        tick(); tick();
    endtask

`ifdef CUB_XBAR_STAT_EN
    task automatic test_stats();
        logic [NO-1:0][NI-1:0] m = '0;
        logic cons;
        int sent = 0;
        int w = 0;
        do_reset();
        m[0][0] = 1'b1;
        load_cfg(m);
        vin[0] = 1'b1; din[0] = beat(0, 0);
        while (sent < 20 && w < 60) begin
            @(negedge clk);
            cons = vin[0] & rin[0];
            tick();
            w++;
            if (cons) begin
                sent++;
                if (sent < 20) din[0] = beat(0, sent); else vin[0] = 1'b0;
            end
        end
        tick(); tick();
        @(negedge clk);
        n_cmp++; if (stat_cnt[0] !== 4'hf) begin n_err++; $display("FAIL stat_sat: got %0d want 15", stat_cnt[0]); end
        n_cmp++; if (stat_cnt[4:1] !== '0) begin n_err++; $display("FAIL stat_others: got %h want 0", stat_cnt[4:1]); end
        vin[0] = 1'b1; stat_clr = 1'b1;
        tick(); tick();
        stat_clr = 1'b0;
        @(negedge clk);
        n_cmp++; if (stat_cnt[0] !== 4'h0) begin n_err++; $display("FAIL stat_clr: got %0d want 0", stat_cnt[0]); end
        tick(); tick();
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (stat_cnt !== '0) begin n_err++; $display("FAIL stat_rst: got %h want 0", stat_cnt); end
        tick();
        rst = 1'b0; vin = '0;
        tick();
    endtask
`endif

    initial begin
        rst = 1'b1;
        test_reset();
        test_identity();
        test_rr_wrap();
        test_multicast();
        test_stall();
        test_cfg();
        test_async_reset();
        test_random();
`ifdef CUB_XBAR_STAT_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
